// File: rtl/debug_pkg.sv
// Types and constants shared by the debug dump sequencer and its byte serializer.
package debug_pkg;

  localparam int BYTES_PER_WORD  = 4;
  localparam int NB_BYTE_CNT     = $clog2(BYTES_PER_WORD);
  localparam int NB_WORD_IDX     = 7;
  localparam int DEF_N_REGS      = 32;
  localparam int DEF_N_MEM_WORDS = 32;

  typedef logic [NB_WORD_IDX-1:0] word_idx_t;

  // Stream layout: PC, cycle count, register file, then data memory.
  localparam word_idx_t IDX_PC   = 7'd0;
  localparam word_idx_t IDX_CYC  = 7'd1;
  localparam word_idx_t IDX_REG0 = 7'd2;

  function automatic word_idx_t idx_mem0(input int n_regs);
    return word_idx_t'(int'(IDX_REG0) + n_regs);
  endfunction

  function automatic word_idx_t total_words(input int n_regs, input int n_mem_words);
    return word_idx_t'(int'(IDX_REG0) + n_regs + n_mem_words);
  endfunction

  localparam word_idx_t IDX_MEM0    = idx_mem0(DEF_N_REGS);
  localparam word_idx_t TOTAL_WORDS = total_words(DEF_N_REGS, DEF_N_MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// Debugger request, register/memory read ports and UART TX handshake of the
// dump sequencer; slave is the sequencer side, master the surrounding system.
interface debug_dump_sequencer_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_MEM_ADDR = 5,
  parameter int NB_BYTE     = 8
);

  logic                   i_dump_req;
  logic [NB_DATA-1:0]     i_pc;
  logic [NB_DATA-1:0]     i_cycle_count;
  logic [NB_REG_ADDR-1:0] o_reg_addr;
  logic [NB_DATA-1:0]     i_reg_data;
  logic [NB_MEM_ADDR-1:0] o_mem_addr;
  logic [NB_DATA-1:0]     i_mem_data;
  logic [NB_BYTE-1:0]     o_tx_data;
  logic                   o_tx_start;
  logic                   i_tx_done;
  logic                   o_busy;
  logic                   o_done;

  modport slave (
    input  i_dump_req, i_pc, i_cycle_count, i_reg_data, i_mem_data, i_tx_done,
    output o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done
  );

  modport master (
    output i_dump_req, i_pc, i_cycle_count, i_reg_data, i_mem_data, i_tx_done,
    input  o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done
  );

endinterface

// File: rtl/tx_word_serializer.sv
// Captures one word and sends it as BYTES_PER_WORD bytes, LSB first, over the
// UART start/done handshake; word_sent pulses with the last byte's done.
module tx_word_serializer
  import debug_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               word_valid,
  input  logic [NB_DATA-1:0] word_data,
  input  logic               tx_done,
  output logic [NB_BYTE-1:0] tx_data,
  output logic               tx_start,
  output logic               word_sent
);

  localparam logic [NB_BYTE_CNT-1:0] LAST_BYTE = NB_BYTE_CNT'(BYTES_PER_WORD - 1);

  state_e                 state_q, state_d;
  logic [NB_DATA-1:0]     shift_q, shift_d;
  logic [NB_BYTE_CNT-1:0] byte_cnt_q, byte_cnt_d;
  logic                   last_byte;

  assign last_byte = (byte_cnt_q == LAST_BYTE);

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (word_valid) state_d = LATCH;
      LATCH:   state_d = START;
      // A done pulse coincident with START is not ours; only WAIT listens.
      START:   state_d = WAIT;
      WAIT:    if (tx_done) state_d = last_byte ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (state_q == LATCH) begin
      shift_d    = word_data;
      byte_cnt_d = '0;
    end else if (state_q == WAIT && tx_done && !last_byte) begin
      shift_d    = shift_q >> NB_BYTE;
      byte_cnt_d = byte_cnt_q + 1'b1;
    end
  end

  always_comb begin
    tx_start  = (state_q == START);
    tx_data   = shift_q[NB_BYTE-1:0];
    word_sent = (state_q == WAIT) && tx_done && last_byte;
  end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams PC, cycle count, register file and data memory out of the debug unit
// over the shared UART TX; owns word sequencing and read-address generation.
module debug_dump_sequencer
  import debug_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int N_REGS      = DEF_N_REGS,
  parameter int NB_REG_ADDR = 5,
  parameter int N_MEM_WORDS = DEF_N_MEM_WORDS,
  parameter int NB_MEM_ADDR = 5,
  parameter int NB_BYTE     = 8
) (
  input logic                   clk,
  input logic                   rst,
  debug_dump_sequencer_if.slave bus
);

  localparam word_idx_t               MEM0_IDX      = idx_mem0(N_REGS);
  localparam word_idx_t               LAST_IDX      = total_words(N_REGS, N_MEM_WORDS) - 1'b1;
  localparam logic [NB_REG_ADDR-1:0]  REG_ADDR_LAST = NB_REG_ADDR'(N_REGS - 1);
  localparam logic [NB_MEM_ADDR-1:0]  MEM_ADDR_LAST = NB_MEM_ADDR'(N_MEM_WORDS - 1);

  state_e                 state_q, state_d;
  word_idx_t              word_idx_q, word_idx_d;
  logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
  logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [NB_DATA-1:0]     pc_snap_q, pc_snap_d;
  logic [NB_DATA-1:0]     cyc_snap_q, cyc_snap_d;
  logic [NB_DATA-1:0]     word_data;
  logic                   word_valid;
  logic                   word_sent;
  logic                   in_reg_sec;
  logic                   in_mem_sec;
  logic [NB_BYTE-1:0]     tx_data;
  logic                   tx_start;

  assign in_reg_sec = (word_idx_q >= IDX_REG0) && (word_idx_q < MEM0_IDX);
  assign in_mem_sec = (word_idx_q >= MEM0_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
      pc_snap_q  <= '0;
      cyc_snap_q <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      reg_addr_q <= reg_addr_d;
      mem_addr_q <= mem_addr_d;
      pc_snap_q  <= pc_snap_d;
      cyc_snap_q <= cyc_snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_dump_req) state_d = FETCH;
      FETCH:   state_d = WAIT;
      WAIT:    if (word_sent) state_d = (word_idx_q == LAST_IDX) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshots and counters restart on an accepted request; addresses advance
  // once per sent word of their section and stick at the last entry.
  always_comb begin
    pc_snap_d  = pc_snap_q;
    cyc_snap_d = cyc_snap_q;
    word_idx_d = word_idx_q;
    reg_addr_d = reg_addr_q;
    mem_addr_d = mem_addr_q;
    if (state_q == IDLE && bus.i_dump_req) begin
      pc_snap_d  = bus.i_pc;
      cyc_snap_d = bus.i_cycle_count;
      word_idx_d = IDX_PC;
      reg_addr_d = '0;
      mem_addr_d = '0;
    end else if (word_sent) begin
      if (word_idx_q != LAST_IDX) word_idx_d = word_idx_q + 1'b1;
      if (in_reg_sec && reg_addr_q != REG_ADDR_LAST) reg_addr_d = reg_addr_q + 1'b1;
      if (in_mem_sec && mem_addr_q != MEM_ADDR_LAST) mem_addr_d = mem_addr_q + 1'b1;
    end
  end

  always_comb begin
    if (word_idx_q == IDX_PC)       word_data = pc_snap_q;
    else if (word_idx_q == IDX_CYC) word_data = cyc_snap_q;
    else if (in_reg_sec)            word_data = bus.i_reg_data;
    else                            word_data = bus.i_mem_data;
  end

  always_comb begin
    word_valid = (state_q == FETCH);
    bus.o_busy = (state_q != IDLE);
    bus.o_done = (state_q == DONE);
  end

  assign bus.o_reg_addr = reg_addr_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_start = tx_start;

  tx_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .word_valid (word_valid),
    .word_data  (word_data),
    .tx_done    (bus.i_tx_done),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .word_sent  (word_sent)
  );

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench: expected bytes are queued when a dump is requested and a
// monitor compares every o_tx_start byte, its timing and the read addresses.
module tb_debug_dump_sequencer;
  import debug_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       first;
    int         gap;
    logic [4:0] reg_a;
    logic [4:0] mem_a;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb[$];
  logic [7:0] rx[$];
  int         done_pulses = 0;
  int         req_cyc = 0;
  int         done_cyc = 0;
  logic       model_done = 1'b0;
  logic       inj_done = 1'b0;
  logic       fetch_done = 1'b0;
  logic       fetch_inj_en = 1'b0;

  debug_dump_sequencer_if bus ();

  debug_dump_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read register file and data memory: reg[k]=k, mem[k]=A0000000+k.
  always @(posedge clk) begin
    bus.i_reg_data <= 32'(bus.o_reg_addr);
    bus.i_mem_data <= 32'hA000_0000 + 32'(bus.o_mem_addr);
  end

  assign bus.i_tx_done = model_done | inj_done | fetch_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // UART model: done 5 cycles after each start; optionally a stray done in FETCH.
  initial begin : tx_model
    int   cd;
    int   starts;
    logic pend_fetch;
    logic cur_last;
    cd = 0; starts = 0; pend_fetch = 1'b0; cur_last = 1'b0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      fetch_done = pend_fetch;
      pend_fetch = 1'b0;
      if (rst === 1'b1) begin
        cd = 0;
        starts = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            model_done = 1'b1;
            done_cyc   = cyc;
            pend_fetch = fetch_inj_en && cur_last;
          end
        end
        if (bus.o_tx_start === 1'b1) begin
          cd       = 5;
          cur_last = (starts % 4 == 3);
          starts++;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_tx_start === 1'b1) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check($sformatf("byte[%0d]", rx.size()), 32'(bus.o_tx_data), 32'(e.data));
          check($sformatf("start_gap[%0d]", rx.size()),
                32'(cyc - (e.first ? req_cyc : done_cyc)), 32'(e.gap));
          check($sformatf("reg_addr[%0d]", rx.size()), 32'(bus.o_reg_addr), 32'(e.reg_a));
          check($sformatf("mem_addr[%0d]", rx.size()), 32'(bus.o_mem_addr), 32'(e.mem_a));
        end
        rx.push_back(bus.o_tx_data);
      end
      if (bus.o_done === 1'b1) begin
        done_pulses++;
        check("done_latency", 32'(cyc - done_cyc), 32'd1);
        check("done_sb_empty", 32'(sb.size()), 32'd0);
      end
    end
  end

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cc);
    exp_t        e;
    logic [31:0] w;
    for (int wi = 0; wi < int'(TOTAL_WORDS); wi++) begin
      if (wi == 0)                     w = pc;
      else if (wi == 1)                w = cc;
      else if (wi < int'(IDX_MEM0))    w = 32'(wi - 2);
      else                             w = 32'hA000_0000 + 32'(wi - int'(IDX_MEM0));
      for (int b = 0; b < 4; b++) begin
        e.data  = w[8*b +: 8];
        e.first = (wi == 0 && b == 0);
        e.gap   = (b == 0) ? 3 : 1;
        e.reg_a = (wi < 2) ? 5'd0 : (wi < int'(IDX_MEM0)) ? 5'(wi - 2) : 5'd31;
        e.mem_a = (wi < int'(IDX_MEM0)) ? 5'd0 : 5'(wi - int'(IDX_MEM0));
        sb.push_back(e);
      end
    end
  endtask

  // Live PC/cycle inputs are scrambled right after the request cycle.
  task automatic issue_dump(input logic [31:0] pc, input logic [31:0] cc);
    @(negedge clk);
    rx.delete();
    push_dump(pc, cc);
    bus.i_pc          = pc;
    bus.i_cycle_count = cc;
    bus.i_dump_req    = 1'b1;
    req_cyc           = cyc;
    @(negedge clk);
    bus.i_dump_req    = 1'b0;
    bus.i_pc          = 32'hFFFF_FFFF;
    bus.i_cycle_count = 32'hFFFF_FFFF;
  endtask

  task automatic wait_dump(input string name);
    int base;
    int waited;
    base = done_pulses;
    waited = 0;
    while (done_pulses == base && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    check({name, "_done_once"}, 32'(done_pulses - base), 32'd1);
    check({name, "_byte_count"}, 32'(rx.size()), 32'd264);
    check({name, "_idle_after"}, 32'(bus.o_busy), 32'd0);
    sb.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_tx_data"}, 32'(bus.o_tx_data), 32'd0);
    check({name, "_tx_start"}, 32'(bus.o_tx_start), 32'd0);
    check({name, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({name, "_done"}, 32'(bus.o_done), 32'd0);
    check({name, "_reg_addr"}, 32'(bus.o_reg_addr), 32'd0);
    check({name, "_mem_addr"}, 32'(bus.o_mem_addr), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] head [8];
    logic [7:0] reg1 [4];
    logic [7:0] tail [4];
    int         waited;
    int         base_done;
    int         base_bytes;
    head = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
    reg1 = '{8'h01, 8'h00, 8'h00, 8'h00};
    tail = '{8'h1F, 8'h00, 8'h00, 8'hA0};

    rst               = 1'b1;
    bus.i_dump_req    = 1'b0;
    bus.i_pc          = '0;
    bus.i_cycle_count = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Idle with random done pulses: nothing may start.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      inj_done = 1'($urandom_range(0, 1));
      check($sformatf("idle_quiet[%0d]", i),
            32'({bus.o_tx_start, bus.o_busy, bus.o_done}), 32'd0);
    end
    @(negedge clk);
    inj_done = 1'b0;

    // Dump 1: full stream with snapshot check.
    issue_dump(32'h0000_0040, 32'h0000_000A);
    wait_dump("dump1");
    if (rx.size() == 264) begin
      for (int i = 0; i < 8; i++) check($sformatf("dump1_head[%0d]", i), 32'(rx[i]), 32'(head[i]));
      for (int i = 0; i < 4; i++) check($sformatf("dump1_reg1[%0d]", i), 32'(rx[12+i]), 32'(reg1[i]));
      for (int i = 0; i < 4; i++) check($sformatf("dump1_tail[%0d]", i), 32'(rx[260+i]), 32'(tail[i]));
    end

    // Dump 2: stray request mid-dump and stray done in every FETCH.
    fetch_inj_en = 1'b1;
    issue_dump(32'h0000_0040, 32'h0000_000A);
    repeat (40) @(negedge clk);
    bus.i_dump_req = 1'b1;
    @(negedge clk);
    bus.i_dump_req = 1'b0;
    wait_dump("dump2");
    fetch_inj_en = 1'b0;
    if (rx.size() == 264) begin
      for (int i = 0; i < 8; i++) check($sformatf("dump2_head[%0d]", i), 32'(rx[i]), 32'(head[i]));
    end

    // Dump 3: reset after 100 bytes, with a simultaneous request.
    issue_dump(32'h0000_0040, 32'h0000_000A);
    waited = 0;
    while (rx.size() < 100 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("reach_byte_100", 32'(rx.size() >= 100), 32'd1);
    rst            = 1'b1;
    bus.i_dump_req = 1'b1;
    sb.delete();
    @(negedge clk);
    bus.i_dump_req = 1'b0;
    check_outputs_zero("midreset");
    @(negedge clk);
    rst        = 1'b0;
    base_done  = done_pulses;
    base_bytes = rx.size();
    repeat (15) @(negedge clk);
    check("after_reset_no_bytes", 32'(rx.size() - base_bytes), 32'd0);
    check("after_reset_no_done", 32'(done_pulses - base_done), 32'd0);
    check("after_reset_not_busy", 32'(bus.o_busy), 32'd0);

    // Dump 4: fresh request restarts from the PC byte.
    issue_dump(32'h0000_0040, 32'h0000_000A);
    wait_dump("dump4");
    if (rx.size() == 264) begin
      for (int i = 0; i < 4; i++) check($sformatf("dump4_head[%0d]", i), 32'(rx[i]), 32'(head[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_dump_sequencer.md
Name: debug_dump_sequencer

Overview:
- Sequences a full processor-state dump out of the debug unit over the shared UART transmitter.
- On request it snapshots PC and cycle count, then walks the register file and data memory through their read ports and streams every 32-bit word as 4 bytes, using the UART TX start/done handshake.
- Sits between the debugger FSM, which issues `i_dump_req` after a step or at halt, and the UART TX.

Parameters:
- NB_DATA, 32, word width of PC, cycle count, registers and memory words.
- N_REGS, 32, number of registers dumped.
- NB_REG_ADDR, 5, register-file address width.
- N_MEM_WORDS, 32, number of data-memory words dumped, starting at address 0.
- NB_MEM_ADDR, 5, data-memory word-address width.
- NB_BYTE, 8, UART byte width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_dump_req  in  1  one-cycle request to start a dump; ignored while busy.
- i_pc  in  NB_DATA  current PC; sampled on the request cycle.
- i_cycle_count  in  NB_DATA  executed-cycle counter; sampled on the request cycle.
- o_reg_addr  out  NB_REG_ADDR  register-file read address.
- i_reg_data  in  NB_DATA  register read data; valid 1 cycle after the address.
- o_mem_addr  out  NB_MEM_ADDR  data-memory read address.
- i_mem_data  in  NB_DATA  memory read data; valid 1 cycle after the address.
- o_tx_data  out  NB_BYTE  byte to transmit.
- o_tx_start  out  1  one-cycle pulse starting a UART transmission.
- i_tx_done  in  1  one-cycle pulse when the UART byte has finished.
- o_busy  out  1  high from the cycle after the request is accepted through the DONE cycle.
- o_done  out  1  one-cycle pulse after the last byte's `i_tx_done`.

Behaviour:
- Reset: state IDLE; all outputs 0; word, byte and address counters 0; snapshot registers 0. Reset mid-dump aborts immediately, with no further `o_tx_start` and no `o_done`.
- Stream order:
  - PC snapshot, then cycle-count snapshot.
  - Registers 0..N_REGS-1, then memory words 0..N_MEM_WORDS-1.
  - Total words = 2+N_REGS+N_MEM_WORDS (66 at defaults); total bytes = 4×words (264).
  - Each word is sent least-significant byte first.
- State FETCH (1 cycle): drive `o_reg_addr` or `o_mem_addr` for the current word. The PC and cycle-count words also pass through FETCH, with addresses held unchanged.
- State LATCH (1 cycle): capture the word from the snapshot or read data into a 32-bit shift register; clear the byte counter.
- State START (1 cycle): `o_tx_start`=1; `o_tx_data` = shift[7:0].
- State WAIT: `o_tx_data` is held stable and `o_tx_start`=0.
  - On `i_tx_done`, if the byte counter < 3: shift right by 8, increment the byte counter, go to START.
  - If the byte counter = 3 and more words remain: advance the word index, go to FETCH.
  - If the byte counter = 3 and this is the last word: go to DONE.
- State DONE (1 cycle): `o_done`=1, then IDLE; `o_busy` falls the cycle after DONE.
- Timing:
  - If `i_dump_req` is sampled high at edge E0, the first `o_tx_start` is high in the 3rd cycle after E0.
  - Within a word, the next `o_tx_start` follows 1 cycle after `i_tx_done`.
  - Across words, it follows 3 cycles after `i_tx_done`.
- Boundary conditions:
  - `i_tx_done` outside WAIT is ignored.
  - `i_dump_req` while busy is ignored; it is not queued.
  - `i_dump_req` and `rst` in the same cycle: reset wins.
  - If `i_tx_done` arrives in the same cycle as START (0-latency TX), the machine still goes to WAIT and waits for the next done pulse.
  - Word index is 7 bits wide; no wrap within a dump.
  - Register/memory address counters saturate at their last value rather than wrap.

Decomposition:
- Shared package (`debug_pkg`) holds:
  - state enumeration: IDLE, FETCH, LATCH, START, WAIT, DONE;
  - BYTES_PER_WORD=4;
  - word-section boundaries: IDX_PC=0, IDX_CYC=1, IDX_REG0=2, IDX_MEM0=2+N_REGS;
  - the total-word constant.
- One natural sub-module, `tx_word_serializer`: the LATCH/START/WAIT 4-byte shift-and-handshake loop with a `word_valid`/`word_sent` interface. The top-level keeps word sequencing and address generation.

Test Plan:
- Reset then idle, with `i_tx_done` toggling randomly -> `o_tx_start`, `o_busy` and `o_done` stay 0.
- TX model returns `i_tx_done` 5 cycles after each start:
  - Stimulus: `i_pc`=0x00000040, `i_cycle_count`=0x0000000A, reg[k]=k, mem[k]=0xA0000000+k; pulse `i_dump_req`.
  - Response: exactly 264 bytes; the first 8 are 40 00 00 00 0A 00 00 00.
  - The bytes for reg1 are 01 00 00 00; the last 4 bytes are 1F 00 00 A0.
  - `o_done` pulses once, 1 cycle after the final `i_tx_done`.
- Change `i_pc` to 0xFFFFFFFF one cycle after the request -> the first 4 bytes are still 40 00 00 00 (snapshot).
- Second `i_dump_req` mid-dump, plus an extra `i_tx_done` while in FETCH -> byte count is still 264 and the order is unchanged.
- Assert `rst` after byte 100 -> next cycle all outputs are 0; a new request restarts from the PC byte.
- Latency check:
  - First `o_tx_start` 3 cycles after the request edge.
  - Intra-word gap is `i_tx_done`+1 cycle; inter-word gap is `i_tx_done`+3 cycles.
  - `o_reg_addr` steps 0..31 and `o_mem_addr` steps 0..31 in order.
